// File: rtl/processor_top_pkg.sv
// Shared definitions for the processor_top core: opcode and funct
// constants, the ALU operation set, the NOP encoding and the ALU itself.
package processor_top_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLT
   } alu_op_e;

   function automatic logic [31:0] alu_calc(input alu_op_e op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] y;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
         default: y = a + b;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/processor_top_register_file.sv
// 32 x 32-bit register file.
// Ports: clk, reset (sync, active-high, clears all registers),
//        rs1_addr/rs2_addr -> rs1_data/rs2_data (combinational reads),
//        wr_en/wr_addr/wr_data (write on rising edge).
// x0 always reads as zero and writes to it are dropped.
module register_file (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   logic [31:0] registers [0:31];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else if (wr_en && (wr_addr != 5'd0)) begin
         registers[wr_addr] <= wr_data;
      end
   end

   assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : registers[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : registers[rs2_addr];

endmodule

// File: rtl/processor_top.sv
// Single-cycle RV32I-subset core with an internal boot ROM.
// Ports: clk, reset (sync, active-high), rx (reserved, ignored),
//        tx (held idle high), result (last non-x0 write-back value).
// ROM_IMAGE selects the built-in program: 0 = boot program, 1 = branch
// test image. Unlisted ROM words read as NOP.
module processor_top
   import processor_top_pkg::*;
#(
   parameter int          ROM_DEPTH = 64,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ROM_IMAGE = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic        tx,
   output logic [31:0] result
);

   localparam int IDX_W = $clog2(ROM_DEPTH);

   logic [31:0] pc;
   logic [31:0] instruction;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_b;
   logic [31:0] imm_j;

   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] alu_b;
   alu_op_e     alu_op;
   logic        wr_en;
   logic        link;
   logic [31:0] wr_data;

   logic        unused_rx;

   function automatic logic [31:0] rom_word(input int idx);
      logic [31:0] w;
      w = NOP_INSN;
      if (ROM_IMAGE == 0) begin
         case (idx)
            0:       w = 32'h00F0_0113;   // addi x2,x0,15
            1:       w = 32'h00F0_0193;   // addi x3,x0,15
            2:       w = 32'h0031_00B3;   // add  x1,x2,x3
            3:       w = 32'h4030_8233;   // sub  x4,x1,x3
            4:       w = 32'h0000_006F;   // jal  x0,0 (halt)
            default: w = NOP_INSN;
         endcase
      end else begin
         case (idx)
            0:       w = 32'hFFF0_0293;   // addi x5,x0,-1
            1:       w = 32'h0052_8333;   // add  x6,x5,x5
            2:       w = 32'h0003_1463;   // bne  x6,x0,+8
            3:       w = 32'h0010_0393;   // addi x7,x0,1
            4:       w = 32'h0020_0413;   // addi x8,x0,2
            default: w = NOP_INSN;
         endcase
      end
      return w;
   endfunction

   // Index truncation makes the pc wrap around the ROM.
   assign instruction = rom_word(int'(pc[IDX_W+1:2]));

   assign opcode = instruction[6:0];
   assign rd     = instruction[11:7];
   assign funct3 = instruction[14:12];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign funct7 = instruction[31:25];

   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
   assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

   assign pc_plus4 = pc + 32'd4;
   assign tx       = 1'b1;
   assign unused_rx = rx;

   register_file reg_file (
      .clk      (clk),
      .reset    (reset),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .wr_en    (wr_en),
      .wr_addr  (rd),
      .wr_data  (wr_data)
   );

   // Decode: anything not explicitly recognised falls through as a NOP.
   always_comb begin
      alu_op  = ALU_ADD;
      alu_b   = rs2_data;
      wr_en   = 1'b0;
      link    = 1'b0;
      pc_next = pc_plus4;
      case (opcode)
         OP_R: begin
            case (funct3)
               F3_ADD_SUB: begin
                  alu_op = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                  wr_en  = (funct7 == F7_BASE) || (funct7 == F7_SUB);
               end
               F3_SLT: begin alu_op = ALU_SLT; wr_en = (funct7 == F7_BASE); end
               F3_XOR: begin alu_op = ALU_XOR; wr_en = (funct7 == F7_BASE); end
               F3_OR:  begin alu_op = ALU_OR;  wr_en = (funct7 == F7_BASE); end
               F3_AND: begin alu_op = ALU_AND; wr_en = (funct7 == F7_BASE); end
               default: wr_en = 1'b0;
            endcase
         end
         OP_I: begin
            alu_b = imm_i;
            case (funct3)
               F3_ADD_SUB: begin alu_op = ALU_ADD; wr_en = 1'b1; end
               F3_XOR:     begin alu_op = ALU_XOR; wr_en = 1'b1; end
               F3_OR:      begin alu_op = ALU_OR;  wr_en = 1'b1; end
               F3_AND:     begin alu_op = ALU_AND; wr_en = 1'b1; end
               default:    wr_en = 1'b0;
            endcase
         end
         OP_BRANCH: begin
            if (((funct3 == F3_BEQ) && (rs1_data == rs2_data)) ||
                ((funct3 == F3_BNE) && (rs1_data != rs2_data)))
               pc_next = pc + imm_b;
         end
         OP_JAL: begin
            wr_en   = 1'b1;
            link    = 1'b1;
            pc_next = pc + imm_j;
         end
         default: ;
      endcase
      wr_data = link ? pc_plus4 : alu_calc(alu_op, rs1_data, alu_b);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc     <= RESET_PC;
         result <= '0;
      end else begin
         pc <= pc_next;
         if (wr_en && (rd != 5'd0)) result <= wr_data;
      end
   end

endmodule

// File: tb/tb_processor_top.sv
module tb_processor_top;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        tx;
   logic        tx_alt;
   logic [31:0] result;
   logic [31:0] result_alt;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] result;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   processor_top dut (
      .clk    (clk),
      .reset  (reset),
      .rx     (rx),
      .tx     (tx),
      .result (result)
   );

   processor_top #(.ROM_IMAGE(1)) dut_alt (
      .clk    (clk),
      .reset  (reset),
      .rx     (rx),
      .tx     (tx_alt),
      .result (result_alt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_final(input string tag);
      check({tag, " x1"}, dut.reg_file.registers[1], 32'h0000_001E);
      check({tag, " x2"}, dut.reg_file.registers[2], 32'h0000_000F);
      check({tag, " x3"}, dut.reg_file.registers[3], 32'h0000_000F);
      check({tag, " x4"}, dut.reg_file.registers[4], 32'h0000_000F);
      check({tag, " pc"}, dut.pc, 32'h0000_0010);
      check({tag, " instruction"}, dut.instruction, 32'h0000_006F);
      check({tag, " result"}, result, 32'h0000_000F);
      check({tag, " tx"}, {31'b0, tx}, 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " pc"}, dut.pc, 32'h0);
      check({tag, " result"}, result, 32'h0);
      check({tag, " tx"}, {31'b0, tx}, 32'd1);
      check({tag, " instruction"}, dut.instruction, 32'h00F0_0113);
      for (int i = 0; i < 32; i++)
         check($sformatf("%s x%0d", tag, i), dut.reg_file.registers[i], 32'h0);
   endtask

   // Random activity on rx for the whole run; it must not influence anything.
   initial begin
      forever begin
         @(negedge clk);
         rx = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [31:0] pc_tab [0:6];
      logic [31:0] res_tab [0:6];
      exp_t e;

      pc_tab  = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h10, 32'h10, 32'h10};
      res_tab = '{32'hF, 32'hF, 32'h1E, 32'hF, 32'hF, 32'hF, 32'hF};

      // Hold reset for 10 edges.
      reset = 1'b1;
      repeat (10) step();
      check_reset_state("reset");

      // Release and follow execution edge by edge.
      reset = 1'b0;
      check("pc before first edge", dut.pc, 32'h0);
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back('{pc: pc_tab[k], result: res_tab[k]});
         step();
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL scoreboard empty at step %0d: observed=0 expected=1", k);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("step%0d pc", k), dut.pc, e.pc);
            check($sformatf("step%0d result", k), result, e.result);
         end
         check($sformatf("step%0d tx", k), {31'b0, tx}, 32'd1);
      end
      repeat (13) step();
      check_final("run1");

      // Mid-program reset: restart, run 3 edges, reset for one edge.
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (3) step();
      check("mid pc after 3 edges", dut.pc, 32'hC);
      check("mid x1 after 3 edges", dut.reg_file.registers[1], 32'h1E);
      reset = 1'b1;
      step();
      check_reset_state("midreset");
      reset = 1'b0;
      repeat (20) step();
      check_final("run2");

      // Alternate image ran in parallel since the last reset release.
      check("alt x5", dut_alt.reg_file.registers[5], 32'hFFFF_FFFF);
      check("alt x6", dut_alt.reg_file.registers[6], 32'hFFFF_FFFE);
      check("alt x7", dut_alt.reg_file.registers[7], 32'h0);
      check("alt x8", dut_alt.reg_file.registers[8], 32'h2);
      check("alt tx", {31'b0, tx_alt}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
